cordic_engine: RTL and testbench

//  Iterative, parametrised CORDIC core with two modes: rotation (sin/cos, vector rotate) and vectoring (atan2/magnitude).

---
 rtl/cordic_engine_if.sv | 27 ++
 rtl/cordic_engine.sv | 205 ++++++++++++++++++++
 tb/tb_cordic_engine.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_engine_if.sv
// cordic_engine_if: job request / result handshake bundle for cordic_engine.
// The master drives jobs and accepts results; the slave is the CORDIC core.
interface cordic_engine_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic                         mode_in;
  logic signed [DATA_WIDTH-1:0] x_in;
  logic signed [DATA_WIDTH-1:0] y_in;
  logic signed [DATA_WIDTH-1:0] z_in;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] x_out;
  logic signed [DATA_WIDTH-1:0] y_out;
  logic signed [DATA_WIDTH-1:0] z_out;

  modport master (
    output in_valid, mode_in, x_in, y_in, z_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out
  );

  modport slave (
    input  in_valid, mode_in, x_in, y_in, z_in, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out
  );
endinterface

// File: rtl/cordic_engine.sv
// cordic_engine: iterative rotation/vectoring CORDIC with quadrant pre-rotation.
// Optional feature macro: CORDIC_GAIN_COMP_EN adds a 1/K gain-compensation stage.
module cordic_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int N_ITER     = 14,
  parameter int GUARD      = 2
) (
  input logic            clk,
  input logic            srst_n,
  cordic_engine_if.slave bus
);
  localparam int  W     = DATA_WIDTH;
  localparam int  XW    = W + 2 + GUARD;
  localparam int  ZW    = W + GUARD;
  localparam int  CW    = $clog2(N_ITER + 1);
  localparam int  LUT_N = 2 ** CW;
  localparam real PI    = 3.14159265358979323846;

  localparam logic signed [XW:0]       XHALF = (XW+1)'((2 ** GUARD) / 2);
  localparam logic [ZW-1:0]            ZHALF = ZW'((2 ** GUARD) / 2);
  localparam logic signed [XW-GUARD:0] S_MAX = (XW-GUARD+1)'(2 ** (W-1) - 1);
  localparam logic signed [XW-GUARD:0] S_MIN = (XW-GUARD+1)'(-(2 ** (W-1)));

  function automatic logic [ZW-1:0] atan_val(input int k);
    real a;
    a = $atan(2.0 ** (-k)) / (2.0 * PI) * (2.0 ** ZW);
    return ZW'(longint'(a));
  endfunction

  function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] v);
    if (v == {1'b1, {(W-1){1'b0}}})
      return {1'b0, {(W-1){1'b1}}};
    return -v;
  endfunction

  function automatic logic signed [W-1:0] rnd_sat(input logic signed [XW-1:0] v);
    logic signed [XW:0]       t;
    logic signed [XW-GUARD:0] s;
    t = (XW+1)'(v) + XHALF;
    s = (XW-GUARD+1)'(t >>> GUARD);
    if (s > S_MAX) return {1'b0, {(W-1){1'b1}}};
    if (s < S_MIN) return {1'b1, {(W-1){1'b0}}};
    return W'(s);
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_GAIN, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;
`endif

  state_t                r_state;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_mode;
  logic [CW-1:0]         r_iter;
  logic signed [XW-1:0]  r_x;
  logic signed [XW-1:0]  r_y;
  logic signed [ZW-1:0]  r_z;
  logic signed [W-1:0]   r_x_out;
  logic signed [W-1:0]   r_y_out;
  logic signed [W-1:0]   r_z_out;

  // Table padded to a power of two so the counter can index it directly.
  logic [ZW-1:0] w_atan_lut [LUT_N];
  for (genvar k = 0; k < LUT_N; k++) begin : g_atan
    localparam logic [ZW-1:0] C_ATAN = (k < N_ITER) ? atan_val(k) : '0;
    assign w_atan_lut[k] = C_ATAN;
  end

  logic                 w_flip;
  logic signed [W-1:0]  w_x_pre;
  logic signed [W-1:0]  w_y_pre;
  logic [W-1:0]         w_z_pre;
  logic signed [XW-1:0] w_x_ld;
  logic signed [XW-1:0] w_y_ld;
  logic signed [ZW-1:0] w_z_ld;

  // Both pre-rotations add pi to z, which is an MSB flip in binary-angle units.
  always_comb begin
    w_flip  = bus.mode_in ? bus.x_in[W-1] : (bus.z_in[W-1] ^ bus.z_in[W-2]);
    w_x_pre = w_flip ? neg_sat(bus.x_in) : bus.x_in;
    w_y_pre = w_flip ? neg_sat(bus.y_in) : bus.y_in;
    w_z_pre = w_flip ? {~bus.z_in[W-1], bus.z_in[W-2:0]} : bus.z_in;
    w_x_ld  = XW'(w_x_pre) <<< GUARD;
    w_y_ld  = XW'(w_y_pre) <<< GUARD;
    w_z_ld  = ZW'(w_z_pre) << GUARD;
  end

  logic                 w_d_pos;
  logic [ZW-1:0]        w_atan;
  logic signed [XW-1:0] w_xs;
  logic signed [XW-1:0] w_ys;
  logic signed [XW-1:0] w_x_nx;
  logic signed [XW-1:0] w_y_nx;
  logic signed [ZW-1:0] w_z_nx;

  always_comb begin
    w_d_pos = r_mode ? r_y[XW-1] : ~r_z[ZW-1];
    w_atan  = w_atan_lut[r_iter];
    w_xs    = r_x >>> r_iter;
    w_ys    = r_y >>> r_iter;
    w_x_nx  = w_d_pos ? r_x - w_ys : r_x + w_ys;
    w_y_nx  = w_d_pos ? r_y + w_xs : r_y - w_xs;
    w_z_nx  = w_d_pos ? r_z - w_atan : r_z + w_atan;
  end

`ifdef CORDIC_GAIN_COMP_EN
  function automatic logic [ZW-1:0] kinv_val();
    real kg;
    kg = 1.0;
    for (int unsigned i = 0; i < N_ITER; i++)
      kg = kg * $sqrt(1.0 + 2.0 ** (-2 * int'(i)));
    return ZW'(longint'((2.0 ** ZW) / kg));
  endfunction

  localparam logic [ZW-1:0]        KINV  = kinv_val();
  localparam logic signed [XW+ZW:0] PHALF = (XW+ZW+1)'(2 ** (ZW-1));

  logic signed [XW+ZW:0] w_xk;
  logic signed [XW+ZW:0] w_yk;
  logic signed [XW-1:0]  w_x_g;
  logic signed [XW-1:0]  w_y_g;

  always_comb begin
    w_xk  = (XW+ZW+1)'(r_x) * (XW+ZW+1)'($signed({1'b0, KINV}));
    w_yk  = (XW+ZW+1)'(r_y) * (XW+ZW+1)'($signed({1'b0, KINV}));
    w_x_g = XW'((w_xk + PHALF) >>> ZW);
    w_y_g = XW'((w_yk + PHALF) >>> ZW);
  end
`endif

  // The counter runs one step past the last micro-rotation; that extra
  // cycle is the output stage (or hands off to the gain stage).
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_iter      <= '0;
      r_x_out     <= '0;
      r_y_out     <= '0;
      r_z_out     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_x        <= w_x_ld;
            r_y        <= w_y_ld;
            r_z        <= w_z_ld;
            r_mode     <= bus.mode_in;
            r_iter     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_ITER;
          end
        end
        S_ITER: begin
          if (r_iter == CW'(N_ITER)) begin
`ifdef CORDIC_GAIN_COMP_EN
            r_state     <= S_GAIN;
`else
            r_x_out     <= rnd_sat(r_x);
            r_y_out     <= rnd_sat(r_y);
            r_z_out     <= W'((r_z + ZHALF) >> GUARD);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
`endif
          end else begin
            r_x    <= w_x_nx;
            r_y    <= w_y_nx;
            r_z    <= w_z_nx;
            r_iter <= r_iter + 1'b1;
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        S_GAIN: begin
          r_x_out     <= rnd_sat(w_x_g);
          r_y_out     <= rnd_sat(w_y_g);
          r_z_out     <= W'((r_z + ZHALF) >> GUARD);
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
`endif
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.x_out     = r_x_out;
  assign bus.y_out     = r_y_out;
  assign bus.z_out     = r_z_out;
endmodule

// File: tb/tb_cordic_engine.sv
// tb_cordic_engine: directed and random jobs checked against an ideal
// trigonometric model (with CORDIC gain K unless gain compensation is built in).
module tb_cordic_engine;
  localparam int  W  = 16;
  localparam int  N  = 14;
  localparam int  G  = 2;
  localparam real PI = 3.14159265358979323846;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT  = N + 2;
  localparam int  X_45 = 16384;
`else
  localparam int  LAT  = N + 1;
  localparam int  X_45 = 9950;
`endif

  logic clk = 1'b0;
  logic srst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  real  kgain;

  cordic_engine_if #(.DATA_WIDTH(W)) bus ();

  cordic_engine #(.DATA_WIDTH(W), .N_ITER(N), .GUARD(G)) dut (
    .clk(clk),
    .srst_n(srst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input int exp,
                           input int tol, input bit wrap);
    int diff;
    logic signed [W-1:0] dw;
    bit ok;
    diff = obs - exp;
    if (wrap) begin
      dw   = W'(diff);
      diff = int'(dw);
    end
    ok = (diff <= tol) && (diff >= -tol);
    n_assert++;
    assert (ok === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, obs, exp, tol);
    end
  endtask

  // Ideal result: rotation rotates (x,y) by z; vectoring returns magnitude and z+atan2.
  task automatic model(input bit mode, input int x, input int y, input int z,
                       output int xe, output int ye, output int ze);
    real th;
    if (!mode) begin
      th = real'(z) * PI / 32768.0;
      xe = int'(kgain * (real'(x) * $cos(th) - real'(y) * $sin(th)));
      ye = int'(kgain * (real'(x) * $sin(th) + real'(y) * $cos(th)));
      ze = 0;
    end else begin
      xe = int'(kgain * $sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
      ye = 0;
      ze = z + int'($atan2(real'(y), real'(x)) * 32768.0 / PI);
    end
  endtask

  task automatic check_result(input string tag, input bit mode, input int x,
                              input int y, input int z, input int tol);
    int xe, ye, ze;
    model(mode, x, y, z, xe, ye, ze);
    check_tol({tag, "_x"}, int'(bus.x_out), xe, tol, 1'b0);
    check_tol({tag, "_y"}, int'(bus.y_out), ye, tol, 1'b0);
    check_tol({tag, "_z"}, int'(bus.z_out), ze, tol, 1'b1);
  endtask

  task automatic start_job(input bit mode, input int x, input int y, input int z);
    int guard_cnt;
    guard_cnt = 0;
    while (bus.in_ready !== 1'b1 && guard_cnt < 200) begin
      @(posedge clk); #1;
      guard_cnt++;
    end
    check_eq("in_ready_before_job", int'(bus.in_ready), 1);
    bus.mode_in  = mode;
    bus.x_in     = W'(x);
    bus.y_in     = W'(y);
    bus.z_in     = W'(z);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (bus.out_valid !== 1'b1 && lat < 200);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_job(input string tag, input bit mode, input int x,
                         input int y, input int z, input int tol);
    int lat;
    start_job(mode, x, y, z);
    wait_result(lat);
    check_eq({tag, "_latency"}, lat, LAT);
    check_result(tag, mode, x, y, z, tol);
    consume();
  endtask

  initial begin
    int  lat;
    bit  saw;
    bit  m;
    real r, a;
    int  x, y, z;

`ifdef CORDIC_GAIN_COMP_EN
    kgain = 1.0;
`else
    kgain = 1.0;
    for (int i = 0; i < N; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2 * i));
`endif
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mode_in   = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.z_in      = '0;

    // Reset state
    srst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", int'(bus.in_ready), 1);
    check_eq("rst_out_valid", int'(bus.out_valid), 0);
    check_eq("rst_x_out", int'(bus.x_out), 0);
    check_eq("rst_y_out", int'(bus.y_out), 0);
    check_eq("rst_z_out", int'(bus.z_out), 0);
    srst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_job("rot_pi4", 1'b0, X_45, 0, 16'h2000, 4);
    run_job("rot_3pi4", 1'b0, 9950, 0, 16'h6000, 4);
    run_job("rot_m3pi4", 1'b0, 9950, 0, -24576, 4);
    run_job("vec_45", 1'b1, 8192, 8192, 0, 4);
    run_job("vec_xneg", 1'b1, -8192, 0, 0, 4);
    run_job("vec_yneg", 1'b1, 0, -12000, 0, 4);

    // Output hold while consumer stalls; in_valid in that window is ignored
    start_job(1'b0, 9950, 0, 16'h2000);
    wait_result(lat);
    check_eq("hold_latency", lat, LAT);
    for (int c = 0; c < 10; c++) begin
      bus.mode_in  = 1'b1;
      bus.x_in     = 16'sd5000;
      bus.y_in     = 16'sd3000;
      bus.z_in     = '0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      check_eq("hold_out_valid", int'(bus.out_valid), 1);
      check_eq("hold_in_ready", int'(bus.in_ready), 0);
    end
    check_result("hold", 1'b0, 9950, 0, 16'h2000, 4);
    bus.in_valid = 1'b0;
    consume();
    check_eq("release_in_ready", int'(bus.in_ready), 1);
    check_eq("release_out_valid", int'(bus.out_valid), 0);
    saw = 1'b0;
    repeat (LAT + 4) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) saw = 1'b1;
    end
    check_eq("ignored_job_no_output", int'(saw), 0);

    // Reset in the middle of a job
    start_job(1'b0, 9950, 0, 16'h2000);
    repeat (5) @(posedge clk);
    #1;
    srst_n = 1'b0;
    @(posedge clk); #1;
    srst_n = 1'b1;
    check_eq("midrst_out_valid", int'(bus.out_valid), 0);
    check_eq("midrst_in_ready", int'(bus.in_ready), 1);
    saw = 1'b0;
    repeat (LAT + 4) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) saw = 1'b1;
    end
    check_eq("midrst_no_output", int'(saw), 0);
    run_job("after_rst", 1'b1, 8192, 8192, 0, 4);

    // Random jobs within the unit circle
    for (int j = 0; j < 24; j++) begin
      m = 1'($urandom_range(0, 1));
      r = real'($urandom_range(m ? 6000 : 0, 15800));
      a = real'($urandom_range(0, 65535)) * 2.0 * PI / 65536.0;
      x = int'(r * $cos(a));
      y = int'(r * $sin(a));
      z = int'($urandom_range(0, 65535)) - 32768;
      run_job(m ? "rand_vec" : "rand_rot", m, x, y, z, 8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
